pitch_event_conditioner: RTL and testbench

//  Converts raw hi/lo pitch flags from fft_analyzer (clk_104mhz domain) into clean single-cycle
//  up/down events on clk_100mhz for game_controller menu navigation. Replaces bare sync+edge logic:

---
 rtl/pitch_event_pkg.sv | 8 +
 rtl/pitch_event_conditioner_if.sv | 7 +
 rtl/synchronize.sv | 11 +
 rtl/pitch_event_conditioner.sv | 93 +++++++++
 tb/tb_pitch_event_conditioner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pitch_event_pkg.sv
// pitch_event_pkg: shared types and timer sizing for the pitch event conditioner.
package pitch_event_pkg;
    typedef enum logic [1:0] {PE_IDLE, PE_QUAL, PE_FIRED, PE_COOLDOWN} pe_state_t;
    typedef enum logic {PE_DIR_LO, PE_DIR_HI} pe_dir_t;
    function automatic int pe_timer_w(input int hold, input int cool);
        return $clog2((hold > cool ? hold : cool) + 1);
    endfunction
endpackage

// File: rtl/pitch_event_conditioner_if.sv
// pitch_event_conditioner_if: pitch flags in, qualified events and debug counters out.
interface pitch_event_conditioner_if #(parameter int CNT_W = 8);
    logic raw_hi, raw_lo, enable, hi_pulse, lo_pulse, busy;
    logic [CNT_W-1:0] hi_count, lo_count;
    modport master(output raw_hi, raw_lo, enable, input hi_pulse, lo_pulse, busy, hi_count, lo_count);
    modport slave(input raw_hi, raw_lo, enable, output hi_pulse, lo_pulse, busy, hi_count, lo_count);
endinterface

// File: rtl/synchronize.sv
// synchronize: NSYNC-deep flop chain bringing an async flag into the local clock domain.
module synchronize #(parameter int NSYNC = 3) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [NSYNC-1:0] sync_q;
    always_ff @(posedge clk) sync_q <= reset ? '0 : {sync_q[NSYNC-2:0], d_i};
    assign q_o = sync_q[NSYNC-1];
endmodule

// File: rtl/pitch_event_conditioner.sv
// pitch_event_conditioner: turns synchronized hi/lo pitch flags into held, exclusive,
// release-rearmed single-cycle events with cooldown and wrapping event counters.
module pitch_event_conditioner import pitch_event_pkg::*; #(
    parameter int NSYNC           = 3,
    parameter int HOLD_CYCLES     = 2_000_000,
    parameter int COOLDOWN_CYCLES = 10_000_000,
    parameter int CNT_W           = 8
) (
    input logic clk_100mhz,
    input logic reset,
    pitch_event_conditioner_if.slave pe
);
    localparam int TW = pe_timer_w(HOLD_CYCLES, COOLDOWN_CYCLES);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    pe_state_t state_q;
    pe_dir_t dir_q, cand_dir;
    logic [TW-1:0] timer_q;
    logic [CNT_W-1:0] hi_count_q, lo_count_q;
    logic hi_pulse_q, lo_pulse_q, busy_q;
    logic s_hi, s_lo, excl_hi, excl_lo, dir_ok, fire;
    synchronize #(.NSYNC(NSYNC)) u_sync_hi (.clk(clk_100mhz), .reset(reset), .d_i(pe.raw_hi), .q_o(s_hi));
    synchronize #(.NSYNC(NSYNC)) u_sync_lo (.clk(clk_100mhz), .reset(reset), .d_i(pe.raw_lo), .q_o(s_lo));
    assign excl_hi = s_hi & ~s_lo;
    assign excl_lo = s_lo & ~s_hi;
    assign dir_ok = dir_q == PE_DIR_HI ? excl_hi : excl_lo;
    assign cand_dir = state_q == PE_IDLE ? (excl_hi ? PE_DIR_HI : PE_DIR_LO) : dir_q;
    // The timer counts qualifying cycles already seen, so the last one lands on HOLD_CYCLES-1.
    assign fire = state_q == PE_IDLE ? (excl_hi | excl_lo) && HOLD_CYCLES == 1
                                     : state_q == PE_QUAL && dir_ok && timer_q == HOLD_LAST;
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q <= PE_IDLE;
            dir_q <= PE_DIR_LO;
            timer_q <= '0;
            hi_pulse_q <= 1'b0;
            lo_pulse_q <= 1'b0;
            busy_q <= 1'b0;
            hi_count_q <= '0;
            lo_count_q <= '0;
        end else if (!pe.enable) begin
            state_q <= PE_IDLE;
            timer_q <= '0;
            hi_pulse_q <= 1'b0;
            lo_pulse_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            hi_pulse_q <= fire && cand_dir == PE_DIR_HI;
            lo_pulse_q <= fire && cand_dir == PE_DIR_LO;
            if (fire && cand_dir == PE_DIR_HI) hi_count_q <= hi_count_q + C_ONE;
            if (fire && cand_dir == PE_DIR_LO) lo_count_q <= lo_count_q + C_ONE;
            if (fire) begin
                state_q <= PE_FIRED;
                dir_q <= cand_dir;
                timer_q <= '0;
                busy_q <= 1'b1;
            end else begin
                unique case (state_q)
                    PE_IDLE: if (excl_hi | excl_lo) begin
                        state_q <= PE_QUAL;
                        dir_q <= cand_dir;
                        timer_q <= T_ONE;
                        busy_q <= 1'b1;
                    end
                    PE_QUAL: if (dir_ok) timer_q <= timer_q + T_ONE;
                    else begin
                        state_q <= PE_IDLE;
                        timer_q <= '0;
                        busy_q <= 1'b0;
                    end
                    // Release of both flags starts the dead time; it counts the release cycle itself.
                    PE_FIRED: if (!(s_hi | s_lo)) begin
                        state_q <= COOLDOWN_CYCLES == 1 ? PE_IDLE : PE_COOLDOWN;
                        timer_q <= COOLDOWN_CYCLES == 1 ? '0 : T_ONE;
                        busy_q <= COOLDOWN_CYCLES != 1;
                    end
                    PE_COOLDOWN: if (timer_q == COOL_LAST) begin
                        state_q <= PE_IDLE;
                        timer_q <= '0;
                        busy_q <= 1'b0;
                    end else timer_q <= timer_q + T_ONE;
                endcase
            end
        end
    end
    assign pe.hi_pulse = hi_pulse_q;
    assign pe.lo_pulse = lo_pulse_q;
    assign pe.busy = busy_q;
    assign pe.hi_count = hi_count_q;
    assign pe.lo_count = lo_count_q;
endmodule

// File: tb/tb_pitch_event_conditioner.sv
// tb_pitch_event_conditioner: directed scenarios plus random flag traffic checked every cycle
// against a run-length / dead-time reference model of the conditioner.
module tb_pitch_event_conditioner;
    localparam int NSYNC = 2, HOLD = 4, COOL = 8, CNT_W = 4;
    localparam int MOD = 1 << CNT_W;
    logic clk_100mhz = 1'b0;
    logic reset = 1'b1;
    int total = 0, bad = 0;
    pitch_event_conditioner_if #(.CNT_W(CNT_W)) pe();
    pitch_event_conditioner #(.NSYNC(NSYNC), .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL), .CNT_W(CNT_W)) dut (
        .clk_100mhz(clk_100mhz), .reset(reset), .pe(pe));
    always #5 clk_100mhz = ~clk_100mhz;

    // Reference: run = consecutive exclusive cycles seen, held = fired and awaiting release,
    // dead = remaining ignored cycles after release.
    bit m_hp, m_lp, m_busy, m_held, m_dir;
    int m_hc = 0, m_lc = 0, m_run = 0, m_dead = 0;
    bit [NSYNC-1:0] m_sh = '0, m_sl = '0;
    always @(posedge clk_100mhz) begin
        bit sh, sl, eh, el;
        sh = m_sh[NSYNC-1];
        sl = m_sl[NSYNC-1];
        eh = sh & ~sl;
        el = sl & ~sh;
        m_hp = 0;
        m_lp = 0;
        if (reset) begin
            m_sh = '0; m_sl = '0; m_hc = 0; m_lc = 0; m_run = 0; m_dead = 0; m_held = 0;
        end else begin
            m_sh = {m_sh[NSYNC-2:0], pe.raw_hi};
            m_sl = {m_sl[NSYNC-2:0], pe.raw_lo};
            if (!pe.enable) begin
                m_run = 0; m_dead = 0; m_held = 0;
            end else if (m_held) begin
                if (!(sh | sl)) begin m_held = 0; m_dead = COOL - 1; end
            end else if (m_dead > 0) m_dead--;
            else begin
                if (m_run == 0) begin
                    if (eh | el) begin m_dir = eh; m_run = 1; end
                end else m_run = (m_dir ? eh : el) ? m_run + 1 : 0;
                if (m_run == HOLD) begin
                    m_run = 0;
                    m_held = 1;
                    if (m_dir) begin m_hp = 1; m_hc = (m_hc + 1) % MOD; end
                    else begin m_lp = 1; m_lc = (m_lc + 1) % MOD; end
                end
            end
        end
        m_busy = m_held || m_dead > 0 || m_run > 0;
    end

    function automatic logic [10:0] obs();
        return {pe.hi_pulse, pe.lo_pulse, pe.busy, pe.hi_count, pe.lo_count};
    endfunction
    function automatic logic [10:0] mdl();
        return {m_hp, m_lp, m_busy, CNT_W'(m_hc), CNT_W'(m_lc)};
    endfunction
    task automatic tick();
        @(negedge clk_100mhz);
    endtask

    task automatic test_reset();
        reset = 1; pe.raw_hi = 0; pe.raw_lo = 0; pe.enable = 1;
        repeat (3) tick();
        total++;
        if (obs() !== 11'h0) begin bad++; $display("FAIL reset_state got=%h exp=000", obs()); end
        total++;
        if (obs() !== mdl()) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs(), mdl()); end
        reset = 0;
        tick();
    endtask

    task automatic test_hold();
        int pc = -1, busy_low = -1, n = 0, hc0 = m_hc;
        pe.raw_hi = 1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            total++;
            if (obs() !== mdl()) begin bad++; $display("FAIL hold c=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (pe.hi_pulse) begin n++; if (pc < 0) pc = i; end
            if (i > 20 && !pe.busy && busy_low < 0) busy_low = i;
            if (i == 20) pe.raw_hi = 0;
        end
        total++;
        if (pc !== 6 || n !== 1) begin bad++; $display("FAIL hold_pulse_time got=%0d/%0d exp=6/1", pc, n); end
        total++;
        if (busy_low !== 30) begin bad++; $display("FAIL hold_busy_fall got=%0d exp=30", busy_low); end
        total++;
        if (pe.hi_count !== CNT_W'(hc0 + 1) || pe.lo_count !== 4'h0) begin
            bad++; $display("FAIL hold_counts got=%h/%h exp=%h/0", pe.hi_count, pe.lo_count, CNT_W'(hc0 + 1));
        end
    endtask

    task automatic test_short();
        int n = 0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) tick();
            if (i > 0) begin
                total++;
                if (obs() !== mdl()) begin bad++; $display("FAIL short c=%0d got=%h exp=%h", i, obs(), mdl()); end
            end
            n += pe.lo_pulse;
            if (i == 6 || i == 12) begin
                total++;
                if (pe.busy !== 1'b0) begin bad++; $display("FAIL short_idle c=%0d busy got=%b exp=0", i, pe.busy); end
            end
            pe.raw_lo = (i < 3) || (i >= 6 && i < 9);
        end
        total++;
        if (n !== 0 || pe.lo_count !== 4'h0) begin bad++; $display("FAIL short_nopulse got=%0d/%h exp=0/0", n, pe.lo_count); end
    endtask

    task automatic test_conflict();
        int pc = -1, n = 0, hc0 = m_hc;
        pe.raw_hi = 1; pe.raw_lo = 1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            total++;
            if (obs() !== mdl()) begin bad++; $display("FAIL conflict c=%0d got=%h exp=%h", i, obs(), mdl()); end
            n += pe.hi_pulse + pe.lo_pulse;
            if (pe.hi_pulse && pc < 0) pc = i;
            if (i == 30) pe.raw_lo = 0;
            if (i == 50) pe.raw_hi = 0;
        end
        total++;
        if (pc !== 36 || n !== 1) begin bad++; $display("FAIL conflict_pulse got=%0d/%0d exp=36/1", pc, n); end
        total++;
        if (pe.hi_count !== CNT_W'(hc0 + 1)) begin bad++; $display("FAIL conflict_count got=%h exp=%h", pe.hi_count, CNT_W'(hc0 + 1)); end
    endtask

    task automatic test_cooldown();
        int p1 = -1, p2 = -1, n = 0;
        pe.raw_hi = 1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            total++;
            if (obs() !== mdl()) begin bad++; $display("FAIL cooldown c=%0d got=%h exp=%h", i, obs(), mdl()); end
            if (pe.hi_pulse) begin n++; if (p1 < 0) p1 = i; else p2 = i; end
            if (i == 30) begin
                total++;
                if (pe.busy !== 1'b0) begin bad++; $display("FAIL cooldown_idle busy got=%b exp=0", pe.busy); end
            end
            if (i == 20) pe.raw_hi = 0;
            if (i == 23) pe.raw_hi = 1;
            if (i == 43) pe.raw_hi = 0;
        end
        total++;
        if (p1 !== 6 || p2 !== 34 || n !== 2) begin bad++; $display("FAIL cooldown_pulses got=%0d,%0d,%0d exp=6,34,2", p1, p2, n); end
    endtask

    task automatic test_wrap();
        reset = 1;
        tick();
        reset = 0;
        for (int k = 1; k <= 16; k++) begin
            pe.raw_lo = 1;
            for (int i = 1; i <= 18; i++) begin
                tick();
                total++;
                if (obs() !== mdl()) begin bad++; $display("FAIL wrap k=%0d c=%0d got=%h exp=%h", k, i, obs(), mdl()); end
                if (i == 6) pe.raw_lo = 0;
            end
            total++;
            if (pe.lo_count !== CNT_W'(k % MOD) || pe.hi_count !== 4'h0) begin
                bad++; $display("FAIL wrap_count k=%0d got=%h/%h exp=%h/0", k, pe.lo_count, pe.hi_count, CNT_W'(k % MOD));
            end
        end
    endtask

    task automatic test_enable_reset();
        int pc = -1;
        pe.raw_hi = 1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i < 17) begin
                total++;
                if (obs() !== mdl()) begin bad++; $display("FAIL enable c=%0d got=%h exp=%h", i, obs(), mdl()); end
            end
            if (pe.hi_pulse && pc < 0) pc = i;
            if (i == 6) begin
                total++;
                if (pe.busy !== 1'b0 || pe.hi_pulse !== 1'b0) begin bad++; $display("FAIL enable_drop got=%b%b exp=00", pe.busy, pe.hi_pulse); end
            end
            if (i == 5) pe.enable = 0;
            if (i == 10) pe.enable = 1;
            if (i == 16) begin reset = 1; pe.raw_hi = 0; end
        end
        total++;
        if (pc !== 14) begin bad++; $display("FAIL enable_requal got=%0d exp=14", pc); end
        total++;
        if (obs() !== 11'h0) begin bad++; $display("FAIL reset_fired got=%h exp=000", obs()); end
        reset = 0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        for (int i = 1; i <= 3000; i++) begin
            tick();
            total++;
            if (obs() !== mdl()) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", i, obs(), mdl()); end
            if ($urandom_range(11) == 0) pe.raw_hi = ~pe.raw_hi;
            if ($urandom_range(13) == 0) pe.raw_lo = ~pe.raw_lo;
            pe.enable = pe.enable ? ($urandom_range(199) != 0) : ($urandom_range(3) == 0);
            reset = $urandom_range(999) == 0;
        end
        reset = 0; pe.enable = 1;
    endtask

    initial begin
        pe.raw_hi = 0; pe.raw_lo = 0; pe.enable = 1;
        test_reset();
        test_hold();
        test_short();
        test_conflict();
        test_cooldown();
        test_wrap();
        test_enable_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
